c_sram_drain: RTL and testbench

//  Read-side master for the C-result SRAM read port of the tile compute system.

---
 rtl/tpu_cdrain_pkg.sv | 13 +
 rtl/cdrain_fifo.sv | 51 +++++
 rtl/c_sram_drain.sv | 185 ++++++++++++++++++
 tb/tb_c_sram_drain.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tpu_cdrain_pkg.sv
// Shared types for the C-result SRAM drain: FSM state encoding, stall counter width
// and an index-width helper.
package tpu_cdrain_pkg;

  typedef enum logic [1:0] {CD_IDLE, CD_ISSUE, CD_DRAIN} cd_state_e;

  localparam int CD_STALL_W = 32;

  function automatic int cd_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cdrain_fifo.sv
// Return-skid FIFO: synchronous write, show-ahead head, occupancy count.
// DEPTH must be a power of two so the pointers wrap naturally.
module cdrain_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head_data,
  output logic [CNT_W-1:0]  count,
  output logic              empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Head is forced to zero when empty so the stream data output is clean out of reset.
  assign empty     = (count_q == '0);
  assign head_data = empty ? '0 : mem[rd_ptr_q];
  assign count     = count_q;

endmodule

// File: rtl/c_sram_drain.sv
// Drains the M x N C tile from the result SRAM in row-major order onto a tagged stream,
// issuing reads only while the skid FIFO has room for every outstanding return.
// Optional CDRAIN_STALL_CNT_EN adds a saturating back-pressure cycle counter (stall_cnt).
module c_sram_drain
  import tpu_cdrain_pkg::*;
#(
  parameter int M          = 8,
  parameter int N          = 8,
  parameter int DATA_W     = 32,
  parameter int ROW_W      = cd_idx_w(M),
  parameter int COL_W      = cd_idx_w(N),
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              rd_en,
  output logic              rd_re,
  output logic [ROW_W-1:0]  rd_row,
  output logic [COL_W-1:0]  rd_col,
  input  logic [DATA_W-1:0] rd_rdata,
  input  logic              rd_rvalid,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic [ROW_W-1:0]  m_row,
  output logic [COL_W-1:0]  m_col,
  output logic              m_last
`ifdef CDRAIN_STALL_CNT_EN
  ,
  output logic [CD_STALL_W-1:0] stall_cnt
`endif
);

  cd_state_e         state_q, state_d;
  logic              busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [ROW_W-1:0]  rd_row_q, rd_row_d, tag_row_q, tag_row_d;
  logic [COL_W-1:0]  rd_col_q, rd_col_d, tag_col_q, tag_col_d;
  logic [CNT_W-1:0]  inflight_q, inflight_d;
  logic [CNT_W-1:0]  fifo_cnt;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_head;
  logic [CNT_W:0]    credit_used;
  logic              pop, push, issue, rd_last, tag_last;
`ifdef CDRAIN_STALL_CNT_EN
  logic [CD_STALL_W-1:0] stall_q, stall_d;
`endif

  cdrain_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (rd_rdata),
    .pop       (pop),
    .head_data (fifo_head),
    .count     (fifo_cnt),
    .empty     (fifo_empty)
  );

  always_comb begin
    pop      = !fifo_empty && m_ready;
    push     = rd_rvalid && (inflight_q != '0);
    rd_last  = (rd_row_q == ROW_W'(M - 1)) && (rd_col_q == COL_W'(N - 1));
    tag_last = (tag_row_q == ROW_W'(M - 1)) && (tag_col_q == COL_W'(N - 1));
    // A pop this cycle frees its slot immediately, so it is netted out of the credit check.
    credit_used = {1'b0, fifo_cnt} - (CNT_W + 1)'(pop) + {1'b0, inflight_q};
    issue    = (state_q == CD_ISSUE) && (credit_used < (CNT_W + 1)'(FIFO_DEPTH));

    state_d    = state_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = err_q;
    rd_row_d   = rd_row_q;
    rd_col_d   = rd_col_q;
    tag_row_d  = tag_row_q;
    tag_col_d  = tag_col_q;
    inflight_d = inflight_q;

    // Returns arrive in order, so the output tag simply follows the handshakes.
    if (pop) begin
      if (tag_col_q == COL_W'(N - 1)) begin
        tag_col_d = '0;
        tag_row_d = tag_row_q + 1'b1;
      end else begin
        tag_col_d = tag_col_q + 1'b1;
      end
    end

    case (state_q)
      CD_IDLE: begin
        if (start) begin
          state_d   = CD_ISSUE;
          busy_d    = 1'b1;
          err_d     = 1'b0;
          rd_row_d  = '0;
          rd_col_d  = '0;
          tag_row_d = '0;
          tag_col_d = '0;
        end
      end
      CD_ISSUE: begin
        if (issue) begin
          if (rd_last) begin
            state_d = CD_DRAIN;
          end else if (rd_col_q == COL_W'(N - 1)) begin
            rd_col_d = '0;
            rd_row_d = rd_row_q + 1'b1;
          end else begin
            rd_col_d = rd_col_q + 1'b1;
          end
        end
      end
      CD_DRAIN: begin
        if (pop && tag_last) begin
          state_d = CD_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = CD_IDLE;
    endcase

    if (issue && !push)      inflight_d = inflight_q + 1'b1;
    else if (!issue && push) inflight_d = inflight_q - 1'b1;

    if (rd_rvalid && (inflight_q == '0)) err_d = 1'b1;

`ifdef CDRAIN_STALL_CNT_EN
    stall_d = stall_q;
    if (state_q == CD_IDLE && start)                    stall_d = '0;
    else if (!fifo_empty && !m_ready && stall_q != '1)  stall_d = stall_q + 1'b1;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= CD_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      rd_row_q   <= '0;
      rd_col_q   <= '0;
      tag_row_q  <= '0;
      tag_col_q  <= '0;
      inflight_q <= '0;
`ifdef CDRAIN_STALL_CNT_EN
      stall_q    <= '0;
`endif
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      rd_row_q   <= rd_row_d;
      rd_col_q   <= rd_col_d;
      tag_row_q  <= tag_row_d;
      tag_col_q  <= tag_col_d;
      inflight_q <= inflight_d;
`ifdef CDRAIN_STALL_CNT_EN
      stall_q    <= stall_d;
`endif
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;
  assign rd_en   = (state_q != CD_IDLE);
  assign rd_re   = issue;
  assign rd_row  = rd_row_q;
  assign rd_col  = rd_col_q;
  assign m_valid = !fifo_empty;
  assign m_data  = fifo_head;
  assign m_row   = tag_row_q;
  assign m_col   = tag_col_q;
  assign m_last  = !fifo_empty && tag_last;
`ifdef CDRAIN_STALL_CNT_EN
  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_c_sram_drain.sv
// Directed bench for c_sram_drain: a 2x2 instance and an 8x8 instance, each fed by a
// small fixed-latency SRAM model returning row*N+col.
module tb_c_sram_drain;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- 2x2 instance ----------------
  logic        start2 = 1'b0, mr2 = 1'b1;
  logic        busy2, done2, err2, rd_en2, rd_re2, mv2, ml2;
  logic        rd_row2, rd_col2, m_row2, m_col2;
  logic [31:0] m_data2, rdata2;
  logic        rvalid2;
  logic [3:0]  pipe_v2 = '0;
  logic [31:0] pipe_d2 [4];
  int          lat2 = 1;

  // ---------------- 8x8 instance ----------------
  logic        start8 = 1'b0, mr8 = 1'b1, spur8 = 1'b0;
  logic        busy8, done8, err8, rd_en8, rd_re8, mv8, ml8;
  logic [2:0]  rd_row8, rd_col8, m_row8, m_col8;
  logic [31:0] m_data8, rdata8;
  logic        rvalid8;
  logic [3:0]  pipe_v8 = '0;
  logic [31:0] pipe_d8 [4];
  int          lat8 = 1;
`ifdef CDRAIN_STALL_CNT_EN
  logic [31:0] stall8, stall2;
`endif

  c_sram_drain #(.M(2), .N(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .busy(busy2), .done(done2), .err(err2),
    .rd_en(rd_en2), .rd_re(rd_re2), .rd_row(rd_row2), .rd_col(rd_col2),
    .rd_rdata(rdata2), .rd_rvalid(rvalid2), .m_valid(mv2), .m_ready(mr2),
    .m_data(m_data2), .m_row(m_row2), .m_col(m_col2), .m_last(ml2)
`ifdef CDRAIN_STALL_CNT_EN
    , .stall_cnt(stall2)
`endif
  );

  c_sram_drain #(.M(8), .N(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .busy(busy8), .done(done8), .err(err8),
    .rd_en(rd_en8), .rd_re(rd_re8), .rd_row(rd_row8), .rd_col(rd_col8),
    .rd_rdata(rdata8), .rd_rvalid(rvalid8), .m_valid(mv8), .m_ready(mr8),
    .m_data(m_data8), .m_row(m_row8), .m_col(m_col8), .m_last(ml8)
`ifdef CDRAIN_STALL_CNT_EN
    , .stall_cnt(stall8)
`endif
  );

  // SRAM models: fixed latency, data = row*N + col.
  assign rvalid2 = pipe_v2[lat2-1];
  assign rdata2  = pipe_d2[lat2-1];
  assign rvalid8 = pipe_v8[lat8-1] | spur8;
  assign rdata8  = pipe_d8[lat8-1];

  always @(posedge clk) begin
    pipe_v2    <= {pipe_v2[2:0], rd_re2};
    pipe_d2[0] <= 32'(rd_row2) * 2 + 32'(rd_col2);
    pipe_v8    <= {pipe_v8[2:0], rd_re8};
    pipe_d8[0] <= 32'(rd_row8) * 8 + 32'(rd_col8);
    for (int i = 1; i < 4; i++) begin
      pipe_d2[i] <= pipe_d2[i-1];
      pipe_d8[i] <= pipe_d8[i-1];
    end
  end

  // Stream monitors: beat count, per-beat pattern mismatches, done pulses and timing.
  int   bc2 = 0, bad2 = 0, dcnt2 = 0, dbad2 = 0;
  logic lhs2 = 1'b0;
  logic [1:0] tag2 [4];
  int   bc8 = 0, bad8 = 0, dcnt8 = 0, dbad8 = 0, re8 = 0;
  logic lhs8 = 1'b0;

  always @(posedge clk) begin
    if (start2 && !busy2 && rst_n) begin
      bc2 <= 0; bad2 <= 0; dcnt2 <= 0; dbad2 <= 0; lhs2 <= 1'b0;
    end else begin
      if (mv2 && mr2) begin
        if (bc2 < 4) tag2[bc2] <= {m_row2, m_col2};
        if (m_data2 !== 32'(bc2) || ml2 !== (bc2 == 3)) bad2 <= bad2 + 1;
        bc2 <= bc2 + 1;
      end
      lhs2 <= mv2 && mr2 && ml2;
      if (done2) begin
        dcnt2 <= dcnt2 + 1;
        if (!lhs2) dbad2 <= dbad2 + 1;
      end
    end
  end

  always @(posedge clk) begin
    if (start8 && !busy8 && rst_n) begin
      bc8 <= 0; bad8 <= 0; dcnt8 <= 0; dbad8 <= 0; re8 <= 0; lhs8 <= 1'b0;
    end else begin
      if (rd_re8) re8 <= re8 + 1;
      if (mv8 && mr8) begin
        if (m_row8 !== 3'(bc8 / 8) || m_col8 !== 3'(bc8 % 8) ||
            m_data8 !== 32'(bc8) || ml8 !== (bc8 == 63)) bad8 <= bad8 + 1;
        bc8 <= bc8 + 1;
      end
      lhs8 <= mv8 && mr8 && ml8;
      if (done8) begin
        dcnt8 <= dcnt8 + 1;
        if (!lhs8) dbad8 <= dbad8 + 1;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Runs the 8x8 instance until done (mode 0: ready=1, mode 2: ready toggles),
  // optionally re-pulsing start once every read has been issued.
  task automatic run8(input string tag, input int mode, input int budget, input bit restart);
    int cyc = 0;
    bit got = 1'b0;
    bit pulsed = 1'b0;
    while (!got && cyc < budget) begin
      @(negedge clk);
      cyc++;
      start8 = 1'b0;
      if (done8) begin
        got = 1'b1;
        check({tag, "_busy_at_done"}, 64'(busy8), 64'd0);
      end else if (restart && !pulsed && busy8 && re8 == 64) begin
        start8 = 1'b1;
        pulsed = 1'b1;
      end
      mr8 = (mode == 2) ? ~mr8 : 1'b1;
    end
    start8 = 1'b0;
    check({tag, "_done_seen"}, 64'(got), 64'd1);
    repeat (3) @(negedge clk);
    check({tag, "_beats"}, 64'(bc8), 64'd64);
    check({tag, "_pattern_bad"}, 64'(bad8), 64'd0);
    check({tag, "_done_cnt"}, 64'(dcnt8), 64'd1);
    check({tag, "_done_timing_bad"}, 64'(dbad8), 64'd0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    // Reset state
    #1;
    check("rst8_ctl", 64'({busy8, done8, err8, rd_en8, rd_re8, mv8, ml8}), 64'd0);
    check("rst8_data", 64'({m_data8, rd_row8, rd_col8, m_row8, m_col8}), 64'd0);
    check("rst2_ctl", 64'({busy2, done2, err2, rd_en2, rd_re2, mv2, ml2}), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 2x2, latency 1, ready always high
    lat2 = 1;
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    check("t1_busy_after_start", 64'(busy2), 64'd1);
    n = 0;
    while (!done2 && n < 50) begin @(negedge clk); n++; end
    check("t1_done_seen", 64'(done2), 64'd1);
    check("t1_busy_at_done", 64'(busy2), 64'd0);
    repeat (3) @(negedge clk);
    check("t1_beats", 64'(bc2), 64'd4);
    check("t1_data_last_bad", 64'(bad2), 64'd0);
    for (int i = 0; i < 4; i++) check($sformatf("t1_tag%0d", i), 64'(tag2[i]), 64'(i));
    check("t1_done_cnt", 64'(dcnt2), 64'd1);
    check("t1_done_timing_bad", 64'(dbad2), 64'd0);

    // 8x8, latency 3, ready held low for 20 cycles: only FIFO_DEPTH reads may issue
    lat8 = 3;
    mr8 = 1'b0;
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (19) @(negedge clk);
    check("t2_reads_while_blocked", 64'(re8), 64'd4);
    check("t2_valid_while_blocked", 64'(mv8), 64'd1);
    check("t2_rd_en", 64'(rd_en8), 64'd1);
    run8("t2", 0, 400, 1'b0);

    // 8x8, latency 2, ready toggling, extra start during DRAIN
    lat8 = 2;
    mr8 = 1'b1;
    @(negedge clk);
    start8 = 1'b1;
    run8("t3", 2, 600, 1'b1);
    mr8 = 1'b1;

    // Spurious return in IDLE
    @(negedge clk);
    spur8 = 1'b1;
    @(negedge clk);
    spur8 = 1'b0;
    check("t4_err_set", 64'(err8), 64'd1);
    check("t4_no_valid", 64'(mv8), 64'd0);
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    check("t4_err_cleared", 64'(err8), 64'd0);
    run8("t4", 0, 400, 1'b0);

`ifdef CDRAIN_STALL_CNT_EN
    // Stall counter: 10 back-pressured cycles with valid data
    mr8 = 1'b0;
    @(negedge clk);
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    n = 0;
    while (!mv8 && n < 20) begin @(negedge clk); n++; end
    check("t5_valid_seen", 64'(mv8), 64'd1);
    repeat (10) @(negedge clk);
    check("t5_stall_cnt", 64'(stall8), 64'd10);
    run8("t5", 0, 400, 1'b0);
`endif

    // Async reset mid-run with reads outstanding; late return then flags err
    lat8 = 3;
    mr8 = 1'b0;
    @(negedge clk);
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t6_rst_ctl", 64'({busy8, done8, err8, rd_en8, rd_re8, mv8, ml8}), 64'd0);
    check("t6_rst_data", 64'({m_data8, rd_row8, rd_col8, m_row8, m_col8}), 64'd0);
`ifdef CDRAIN_STALL_CNT_EN
    check("t6_rst_stall", 64'(stall8), 64'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("t6_late_return_err", 64'(err8), 64'd1);
    check("t6_idle_no_valid", 64'({busy8, mv8}), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
